// File: rtl/led_status_sequencer_pkg.sv
// ============================================================================
// led_status_sequencer_pkg : shared FSM encodings and helpers for the LED
//                            status sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

package led_status_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [31:0] PASS_CODE_DEFAULT = 32'hDEDEDEDE;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_status_sequencer_rr_arbiter.sv
// ============================================================================
// led_status_sequencer_rr_arbiter : round-robin arbiter, one-hot grant plus
//                                   index, pointer moves past the winner.  Rev 1.0
// ============================================================================
`default_nettype none

module led_status_sequencer_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_sys_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               enable,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx
);

  logic [1:0]           ptr_q;
  logic [1:0]           ptr_d;
  logic                 found;
  logic [2*NUM_REQ-1:0] rotated;
  logic [2:0]           cand;
  logic [2:0]           nxt;

  // Rotating a doubled copy puts the pointer's requester at bit 0.
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    cand      = 3'd0;
    rotated   = {req_valid, req_valid} >> ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rotated[k]) begin
        found = 1'b1;
        cand  = 3'(ptr_q) + 3'(k);
        if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
        grant_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = enable && found && (grant_idx == 2'(i));
    end
  end

  always_comb begin
    nxt = 3'(grant_idx) + 3'd1;
    if (nxt >= 3'(NUM_REQ)) nxt = 3'd0;
    ptr_d = accept ? nxt[1:0] : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_sys_n) ptr_q <= 2'd0;
    else            ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/led_status_sequencer.sv
// ============================================================================
// led_status_sequencer : arbitrates status codes onto the LED word, holding
//                        each one and latching on the pass signature.  Rev 1.0
// ============================================================================
`default_nettype none

module led_status_sequencer
  import led_status_sequencer_pkg::*;
#(
  parameter int          NUM_REQ     = 2,
  parameter int          HOLD_CYCLES = 25_000_000,
  parameter logic [31:0] PASS_CODE   = PASS_CODE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_sys_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_code,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  clear,
  output logic [31:0]           LEDS,
  output logic                  busy,
  output logic                  locked,
  output logic [1:0]            grant_id,
  output logic [7:0]            drop_cnt
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [31:0]        leds_q, leds_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               arb_enable;
  logic [NUM_REQ-1:0] arb_grant;
  logic [1:0]         arb_idx;
  logic               xfer;
  logic [31:0]        sel_code;

  led_status_sequencer_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_sys_n (rst_sys_n),
    .req_valid (req_valid),
    .enable    (arb_enable),
    .accept    (xfer),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign req_ready = arb_grant;
  assign xfer      = |(req_valid & arb_grant);

  always_comb begin
    sel_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == 2'(i)) sel_code = req_code[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_sys_n) begin
      state_q    <= ST_IDLE;
      leds_q     <= '0;
      grant_id_q <= '0;
      drop_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      leds_q     <= leds_d;
      grant_id_q <= grant_id_d;
      drop_cnt_q <= drop_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // clear overrides every state; drop count and arbiter pointer survive it.
  always_comb begin
    state_d    = state_q;
    leds_d     = leds_q;
    grant_id_d = grant_id_q;
    drop_cnt_d = drop_cnt_q;
    cnt_d      = cnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      leds_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            leds_d     = sel_code;
            grant_id_d = arb_idx;
            if (sel_code == PASS_CODE) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        ST_LOCKED: begin
          if (xfer) begin
            grant_id_d = arb_idx;
            drop_cnt_d = sat_inc8(drop_cnt_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == ST_HOLD);
    locked     = (state_q == ST_LOCKED);
    arb_enable = rst_sys_n && !clear && (state_q != ST_HOLD);
  end

  assign LEDS     = leds_q;
  assign grant_id = grant_id_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_led_status_sequencer.sv
// ============================================================================
// tb_led_status_sequencer : scenario bench for led_status_sequencer with a
//                           queue of expected accepted codes.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_led_status_sequencer;

  localparam int          NUM_REQ = 2;
  localparam int          HOLD    = 4;
  localparam logic [31:0] CODE_A  = 32'hAAAAAAA0;
  localparam logic [31:0] CODE_B  = 32'hBBBBBBB0;
  localparam logic [31:0] CODE_C  = 32'hCCCCCCC0;
  localparam logic [31:0] PASS    = 32'hDEDEDEDE;

  logic                  clk = 1'b0;
  logic                  rst_sys_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_code;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  clear;
  logic [31:0]           LEDS;
  logic                  busy;
  logic                  locked;
  logic [1:0]            grant_id;
  logic [7:0]            drop_cnt;

  typedef struct packed {
    logic [31:0] code;
    logic [1:0]  id;
  } exp_t;

  exp_t sb[$];
  exp_t exp_item;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  led_status_sequencer #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD),
    .PASS_CODE   (PASS)
  ) dut (
    .clk       (clk),
    .rst_sys_n (rst_sys_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .clear     (clear),
    .LEDS      (LEDS),
    .busy      (busy),
    .locked    (locked),
    .grant_id  (grant_id),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    rst_sys_n = 1'b0;
    clear     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_sys_n = 1'b1;
  endtask

  task automatic pop_expected(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else    e = '0;
  endtask

  task automatic test_reset();
    bit ok;
    rst_sys_n = 1'b0;
    clear     = 1'b0;
    req_valid = 2'b11;
    req_code  = {CODE_C, CODE_B};
    tick();
    tick();
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    n_checks++; if (LEDS !== 32'h0) begin n_fail++; $display("FAIL reset_leds: got %h expected 0", LEDS); end
    n_checks++; if (busy !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy=%b locked=%b expected 0/0", busy, locked); end
    n_checks++; if (grant_id !== 2'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnts: grant_id=%0d drop_cnt=%0d expected 0/0", grant_id, drop_cnt); end
    rst_sys_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    tick();
    #1;
    n_checks++; if (LEDS !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: LEDS=%h busy=%b expected 0/0", LEDS, busy); end
    ok = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    req_code[31:0] = CODE_A;
    req_valid      = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    sb.push_back('{code: CODE_A, id: 2'd0});
    tick();
    req_code[31:0] = CODE_B;
    #1;
    pop_expected(exp_item, ok);
    n_checks++; if (!ok || LEDS !== exp_item.code || grant_id !== exp_item.id) begin n_fail++; $display("FAIL single_leds: LEDS=%h id=%0d expected %h id %0d", LEDS, grant_id, exp_item.code, exp_item.id); end
    for (int c = 1; c <= HOLD; c++) begin
      if (c > 1) begin tick(); #1; end
      n_checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL single_hold_c%0d: busy=%b ready=%b expected 1/00", c, busy, req_ready); end
    end
    tick();
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 2'b01) begin n_fail++; $display("FAIL single_rearm: busy=%b ready=%b expected 0/01", busy, req_ready); end
    sb.push_back('{code: CODE_B, id: 2'd0});
    tick();
    req_valid = 2'b00;
    #1;
    pop_expected(exp_item, ok);
    n_checks++; if (!ok || LEDS !== exp_item.code || grant_id !== exp_item.id) begin n_fail++; $display("FAIL single_second: LEDS=%h id=%0d expected %h id %0d", LEDS, grant_id, exp_item.code, exp_item.id); end
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    int last_accept;
    int waited;
    logic [1:0] exp_ready;
    do_reset();
    req_code    = {CODE_C, CODE_B};
    req_valid   = 2'b11;
    last_accept = 0;
    #1;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (req_ready === 2'b00 && waited < 20) begin
        tick();
        #1;
        waited++;
      end
      n_checks++; if (waited >= 20) begin n_fail++; $display("FAIL rr_timeout_g%0d: waited %0d cycles, required grant within 20", g, waited); end
      if (g > 0) begin
        n_checks++; if (cycle - last_accept != HOLD + 1) begin n_fail++; $display("FAIL rr_spacing_g%0d: got %0d cycles expected %0d", g, cycle - last_accept, HOLD + 1); end
      end
      last_accept = cycle;
      exp_ready = (g % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_grant_g%0d: got %b expected %b", g, req_ready, exp_ready); end
      sb.push_back('{code: (g % 2 == 0) ? CODE_B : CODE_C, id: 2'(g % 2)});
      tick();
      #1;
      pop_expected(exp_item, ok);
      n_checks++; if (!ok || LEDS !== exp_item.code || grant_id !== exp_item.id) begin n_fail++; $display("FAIL rr_leds_g%0d: LEDS=%h id=%0d expected %h id %0d", g, LEDS, grant_id, exp_item.code, exp_item.id); end
    end
    req_valid = 2'b00;
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_locked();
    bit ok;
    int exp_drop;
    req_code[63:32] = PASS;
    req_valid       = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL lock_ready: got %b expected 10", req_ready); end
    sb.push_back('{code: PASS, id: 2'd1});
    tick();
    req_code[31:0] = CODE_A;
    req_valid      = 2'b01;
    #1;
    pop_expected(exp_item, ok);
    n_checks++; if (!ok || LEDS !== exp_item.code || grant_id !== exp_item.id) begin n_fail++; $display("FAIL lock_leds: LEDS=%h id=%0d expected %h id %0d", LEDS, grant_id, exp_item.code, exp_item.id); end
    n_checks++; if (locked !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL lock_flags: locked=%b busy=%b expected 1/0", locked, busy); end
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL lock_drop_ready: got %b expected 01", req_ready); end
    tick();
    exp_drop = 1;
    #1;
    n_checks++; if (LEDS !== PASS || drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL lock_first_drop: LEDS=%h drop_cnt=%0d expected %h/%0d", LEDS, drop_cnt, PASS, exp_drop); end
    for (int i = 0; i < 300; i++) begin
      tick();
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    #1;
    n_checks++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL lock_saturate: drop_cnt=%0d expected %0d", drop_cnt, exp_drop); end
    n_checks++; if (LEDS !== PASS || locked !== 1'b1) begin n_fail++; $display("FAIL lock_frozen: LEDS=%h locked=%b expected %h/1", LEDS, locked, PASS); end
    req_valid = 2'b00;
  endtask

  task automatic test_clear_locked();
    do_reset();
    req_code[63:32] = PASS;
    req_valid       = 2'b10;
    tick();
    req_code[31:0] = CODE_A;
    req_valid      = 2'b01;
    tick();
    clear = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL clr_lock_ready: got %b expected 00", req_ready); end
    tick();
    clear     = 1'b0;
    req_valid = 2'b00;
    #1;
    n_checks++; if (locked !== 1'b0 || LEDS !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_lock_state: locked=%b LEDS=%h busy=%b expected 0/0/0", locked, LEDS, busy); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_lock_drop: drop_cnt=%0d expected 1", drop_cnt); end
  endtask

  task automatic test_clear_hold();
    bit ok;
    req_code[31:0] = CODE_A;
    req_valid      = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL clr_hold_wrap: got %b expected 01", req_ready); end
    sb.push_back('{code: CODE_A, id: 2'd0});
    tick();
    req_valid = 2'b00;
    #1;
    pop_expected(exp_item, ok);
    n_checks++; if (!ok || LEDS !== exp_item.code || grant_id !== exp_item.id) begin n_fail++; $display("FAIL clr_hold_leds: LEDS=%h id=%0d expected %h id %0d", LEDS, grant_id, exp_item.code, exp_item.id); end
    tick();
    clear           = 1'b1;
    req_code[63:32] = CODE_C;
    req_valid       = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL clr_hold_cycle: ready=%b busy=%b expected 00/1", req_ready, busy); end
    tick();
    clear = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || LEDS !== 32'h0 || locked !== 1'b0) begin n_fail++; $display("FAIL clr_hold_idle: busy=%b LEDS=%h locked=%b expected 0/0/0", busy, LEDS, locked); end
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL clr_hold_regrant: got %b expected 10", req_ready); end
    sb.push_back('{code: CODE_C, id: 2'd1});
    tick();
    req_valid = 2'b00;
    #1;
    pop_expected(exp_item, ok);
    n_checks++; if (!ok || LEDS !== exp_item.code || grant_id !== exp_item.id || busy !== 1'b1) begin n_fail++; $display("FAIL clr_hold_accept: LEDS=%h id=%0d busy=%b expected %h id %0d busy 1", LEDS, grant_id, busy, exp_item.code, exp_item.id); end
  endtask

  initial begin
    rst_sys_n = 1'b0;
    clear     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_locked();
    test_clear_locked();
    test_clear_hold();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
